// File: rtl/song_sequencer_ctrl.sv
// -----------------------------------------------------------------------------
// song_sequencer_ctrl
//
// Purpose:
//   Plays a melody stored in an external synchronous ROM, one note at a time.
//   Each ROM word holds a note index [7:4] and a length in beats [3:0]; a
//   length of zero marks the end of the song. Each note is held for its
//   number of beat_tick pulses. An optional one-beat muted gap can follow
//   every note. The block handles play / pause / stop / loop control and
//   drives the tone generator's divider and mute inputs.
//
// Parameters:
//   ADDR_W  melody ROM address width (song holds at most 2**ADDR_W entries)
//   GAP_EN  1 = insert a one-beat muted gap after every note
//
// Ports:
//   i_clk        clock
//   i_rst_n      synchronous active-low reset
//   i_play       pulse: start from IDLE, resume from PAUSE
//   i_pause      pulse: pause from PLAY/GAP, resume from PAUSE
//   i_stop       pulse: abort to IDLE
//   i_loop_en    level: restart at address 0 when the song ends
//   i_beat_tick  one-cycle beat strobe
//   o_rom_addr   melody ROM address (registered)
//   i_rom_data   ROM word, valid one cycle after o_rom_addr
//   o_note_idx   current note index (registered)
//   o_note_div   divider value for o_note_idx (combinational lookup)
//   o_mute       1 = tone generator silent
//   o_busy       1 in every state except IDLE
//   o_done       one-cycle pulse on normal (non-looped) song completion
// -----------------------------------------------------------------------------
module song_sequencer_ctrl #(
    parameter int ADDR_W = 6,
    parameter bit GAP_EN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_play,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_loop_en,
    input  logic              i_beat_tick,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [7:0]        i_rom_data,
    output logic [3:0]        o_note_idx,
    output logic [19:0]       o_note_div,
    output logic              o_mute,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_PAUSE
    } state_t;

    // Divider value for each of the 16 notes of the shared table.
    localparam logic [19:0] DIV_TABLE [16] = '{
        20'd90909, 20'd81632, 20'd76628, 20'd68259,
        20'd60606, 20'd57306, 20'd51020, 20'd45454,
        20'd40485, 20'd38167, 20'd34013, 20'd30303,
        20'd28653, 20'd25510, 20'd22727, 20'd20242
    };

    state_t            r_state;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [3:0]        r_note_idx;
    logic [3:0]        r_beat_cnt;
    logic              r_mute;
    logic              r_done;
    // Which state PAUSE returns to: 0 = PLAY, 1 = GAP.
    logic              r_saved_gap;

    logic [3:0]        w_rom_note;
    logic [3:0]        w_rom_beats;
    logic              w_last_addr;
    logic              w_last_beat;
    logic              w_resume;

    assign w_rom_note  = i_rom_data[7:4];
    assign w_rom_beats = i_rom_data[3:0];
    // The song never wraps past the top address on its own; reaching it
    // without an end marker is treated as the end of the song.
    assign w_last_addr = (r_rom_addr == {ADDR_W{1'b1}});
    // "<= 1" rather than "== 1" keeps the counter from ever wrapping below 0.
    assign w_last_beat = (r_beat_cnt <= 4'd1);
    assign w_resume    = i_play | i_pause;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_rom_addr  <= '0;
            r_note_idx  <= 4'd0;
            r_beat_cnt  <= 4'd0;
            r_mute      <= 1'b1;
            r_done      <= 1'b0;
            r_saved_gap <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_stop) begin
                // Abort: everything returns to its idle value except the
                // note, which keeps its last index/divider.
                r_state     <= S_IDLE;
                r_rom_addr  <= '0;
                r_beat_cnt  <= 4'd0;
                r_mute      <= 1'b1;
                r_saved_gap <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_play) begin
                            r_state    <= S_FETCH;
                            r_rom_addr <= '0;
                        end
                    end

                    // ROM read in flight; data is sampled in LOAD.
                    S_FETCH: begin
                        r_state <= S_LOAD;
                    end

                    S_LOAD: begin
                        if (w_rom_beats == 4'd0) begin
                            // End marker.
                            r_rom_addr <= '0;
                            r_mute     <= 1'b1;
                            if (i_loop_en) begin
                                r_state <= S_FETCH;
                            end else begin
                                r_state <= S_IDLE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_note_idx <= w_rom_note;
                            r_beat_cnt <= w_rom_beats;
                            r_mute     <= 1'b0;
                            r_state    <= S_PLAY;
                        end
                    end

                    S_PLAY: begin
                        if (i_pause) begin
                            // A tick arriving with the pause is dropped.
                            r_state     <= S_PAUSE;
                            r_saved_gap <= 1'b0;
                            r_mute      <= 1'b1;
                        end else if (i_beat_tick) begin
                            r_beat_cnt <= w_last_beat ? 4'd0 : r_beat_cnt - 4'd1;
                            if (w_last_beat) begin
                                if (GAP_EN) begin
                                    r_state <= S_GAP;
                                    r_mute  <= 1'b1;
                                end else if (w_last_addr) begin
                                    r_rom_addr <= '0;
                                    r_mute     <= 1'b1;
                                    if (i_loop_en) begin
                                        r_state <= S_FETCH;
                                    end else begin
                                        r_state <= S_IDLE;
                                        r_done  <= 1'b1;
                                    end
                                end else begin
                                    // Back-to-back: the previous note keeps
                                    // sounding until the next one loads.
                                    r_rom_addr <= r_rom_addr + ADDR_W'(1);
                                    r_state    <= S_FETCH;
                                end
                            end
                        end
                    end

                    S_GAP: begin
                        if (i_pause) begin
                            r_state     <= S_PAUSE;
                            r_saved_gap <= 1'b1;
                            r_mute      <= 1'b1;
                        end else if (i_beat_tick) begin
                            if (w_last_addr) begin
                                r_rom_addr <= '0;
                                r_mute     <= 1'b1;
                                if (i_loop_en) begin
                                    r_state <= S_FETCH;
                                end else begin
                                    r_state <= S_IDLE;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_rom_addr <= r_rom_addr + ADDR_W'(1);
                                r_state    <= S_FETCH;
                            end
                        end
                    end

                    S_PAUSE: begin
                        // beat_tick is ignored; beat counter stays frozen.
                        if (w_resume) begin
                            r_state <= r_saved_gap ? S_GAP : S_PLAY;
                            r_mute  <= r_saved_gap;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_mute  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_rom_addr = r_rom_addr;
    assign o_note_idx = r_note_idx;
    assign o_note_div = DIV_TABLE[r_note_idx];
    assign o_mute     = r_mute;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;

endmodule

// File: tb/tb_song_sequencer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_song_sequencer_ctrl
//
// Two sequencers share the control inputs:
//   A: ADDR_W=6, GAP_EN=1 (normal / loop / pause / simultaneous-event cases)
//   B: ADDR_W=2, GAP_EN=0 (song with no end marker, back-to-back notes)
// Each has its own behavioural model that is stepped on every clock edge and
// compared with the DUT outputs on every falling edge. Directed scenarios add
// literal expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_song_sequencer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, play, pause, stop, loop_en, beat_tick;
    logic [5:0] addr_a;
    logic [1:0] addr_b;
    logic [7:0] rdata_a, rdata_b;
    logic [3:0] note_a, note_b;
    logic [19:0] div_a, div_b;
    logic       mute_a, mute_b, busy_a, busy_b, done_a, done_b;

    logic [7:0] rom_a [64];
    logic [7:0] rom_b [4];

    always @(posedge clk) begin
        rdata_a <= rom_a[addr_a];
        rdata_b <= rom_b[addr_b];
    end

    song_sequencer_ctrl #(.ADDR_W(6), .GAP_EN(1'b1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_play(play), .i_pause(pause),
        .i_stop(stop), .i_loop_en(loop_en), .i_beat_tick(beat_tick),
        .o_rom_addr(addr_a), .i_rom_data(rdata_a), .o_note_idx(note_a),
        .o_note_div(div_a), .o_mute(mute_a), .o_busy(busy_a), .o_done(done_a)
    );

    song_sequencer_ctrl #(.ADDR_W(2), .GAP_EN(1'b0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_play(play), .i_pause(pause),
        .i_stop(stop), .i_loop_en(loop_en), .i_beat_tick(beat_tick),
        .o_rom_addr(addr_b), .i_rom_data(rdata_b), .o_note_idx(note_b),
        .o_note_div(div_b), .o_mute(mute_b), .o_busy(busy_b), .o_done(done_b)
    );

    int DIV [16] = '{90909, 81632, 76628, 68259, 60606, 57306, 51020, 45454,
                     40485, 38167, 34013, 30303, 28653, 25510, 22727, 20242};

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 fetching, 2 loading, 3 sounding, 4 gap, 5 paused
    typedef struct packed {
        int ph;
        int addr;
        int note;
        int left;
        int mute;
        int done;
        int res_ph;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t song_end(mdl_t m, bit lp);
        mdl_t n = m;
        n.addr = 0;
        n.mute = 1;
        if (lp) n.ph = 1;
        else begin
            n.ph = 0;
            n.done = 1;
        end
        return n;
    endfunction

    function automatic mdl_t next_entry(mdl_t m, int last, bit lp);
        mdl_t n = m;
        if (m.addr == last) n = song_end(m, lp);
        else begin
            n.addr = m.addr + 1;
            n.ph = 1;
        end
        return n;
    endfunction

    function automatic mdl_t step(mdl_t m, int last, bit gap_en, logic [7:0] data,
                                  bit rn, bit pl, bit pz, bit st, bit lp, bit tk);
        mdl_t n = m;
        n.done = 0;
        if (!rn) begin
            n.ph = 0; n.addr = 0; n.note = 0; n.left = 0; n.mute = 1; n.res_ph = 3;
            return n;
        end
        if (st) begin
            n.ph = 0; n.addr = 0; n.left = 0; n.mute = 1; n.res_ph = 3;
            return n;
        end
        case (m.ph)
            0: if (pl) begin n.ph = 1; n.addr = 0; end
            1: n.ph = 2;
            2: begin
                if (data[3:0] == 4'd0) n = song_end(n, lp);
                else begin
                    n.note = int'(data[7:4]);
                    n.left = int'(data[3:0]);
                    n.mute = 0;
                    n.ph = 3;
                end
            end
            3: begin
                if (pz) begin n.ph = 5; n.res_ph = 3; n.mute = 1; end
                else if (tk) begin
                    n.left = m.left - 1;
                    if (n.left == 0) begin
                        if (gap_en) begin n.ph = 4; n.mute = 1; end
                        else n = next_entry(n, last, lp);
                    end
                end
            end
            4: begin
                if (pz) begin n.ph = 5; n.res_ph = 4; n.mute = 1; end
                else if (tk) n = next_entry(n, last, lp);
            end
            default: begin
                if (pl || pz) begin
                    n.ph = m.res_ph;
                    n.mute = (m.res_ph == 3) ? 0 : 1;
                end
            end
        endcase
        return n;
    endfunction

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;
    bit cmp_on = 0;
    bit auto_tick = 1;
    int tick_cnt = 0;
    int aud_a [16];
    int aud_b [16];
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle with the inputs currently driven: compare at the falling
    // edge, step the models at the rising edge, return 1 time unit later.
    task automatic clk1();
        if (auto_tick) beat_tick = (tick_cnt % 4 == 0);
        tick_cnt++;
        @(negedge clk);
        if (cmp_on) begin
            chk("a_rom_addr", 32'(addr_a), ma.addr);
            chk("a_note_idx", 32'(note_a), ma.note);
            chk("a_note_div", 32'(div_a), DIV[ma.note]);
            chk("a_mute", 32'(mute_a), ma.mute);
            chk("a_busy", 32'(busy_a), (ma.ph != 0) ? 1 : 0);
            chk("a_done", 32'(done_a), ma.done);
            chk("b_rom_addr", 32'(addr_b), mb.addr);
            chk("b_note_idx", 32'(note_b), mb.note);
            chk("b_note_div", 32'(div_b), DIV[mb.note]);
            chk("b_mute", 32'(mute_b), mb.mute);
            chk("b_busy", 32'(busy_b), (mb.ph != 0) ? 1 : 0);
            chk("b_done", 32'(done_b), mb.done);
        end
        if (beat_tick && mute_a === 1'b0) aud_a[note_a]++;
        if (beat_tick && mute_b === 1'b0) aud_b[note_b]++;
        if (done_a === 1'b1) done_cnt_a++;
        if (done_b === 1'b1) done_cnt_b++;
        @(posedge clk);
        ma = step(ma, 63, 1'b1, rom_a[ma.addr], rst_n, play, pause, stop, loop_en, beat_tick);
        mb = step(mb, 3, 1'b0, rom_b[mb.addr], rst_n, play, pause, stop, loop_en, beat_tick);
        #1;
    endtask

    task automatic pulse(input bit p, input bit pz, input bit st);
        play = p; pause = pz; stop = st;
        clk1();
        play = 0; pause = 0; stop = 0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) clk1();
    endtask

    int base1, base5, based;
    int n;

    initial begin
        rst_n = 0; play = 1; pause = 0; stop = 0; loop_en = 0; beat_tick = 0;
        for (int i = 0; i < 64; i++) rom_a[i] = 8'h00;
        for (int i = 0; i < 4; i++) rom_b[i] = 8'h00;
        @(posedge clk); #1;

        // ---- reset with play held high ----
        clk1();
        cmp_on = 1;
        clk1(); clk1();
        rst_n = 1; play = 0;
        chk("rst_rom_addr", 32'(addr_a), 0);
        chk("rst_mute", 32'(mute_a), 1);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_note_div", 32'(div_a), 90909);
        idle_cycles(6);
        chk("rst_no_start", 32'(busy_a), 0);
        $display("scenario reset: checks=%0d", checks);

        // ---- normal song on A, no end marker on B ----
        rom_a[0] = 8'h13; rom_a[1] = 8'h52; rom_a[2] = 8'h00;
        rom_b[0] = 8'h01; rom_b[1] = 8'h21; rom_b[2] = 8'h41; rom_b[3] = 8'h61;
        base1 = aud_a[1]; base5 = aud_a[5]; based = done_cnt_a;
        n = done_cnt_b;
        for (int i = 0; i < 16; i++) aud_b[i] = aud_b[i];
        begin
            int b0, b2, b4, b6;
            b0 = aud_b[0]; b2 = aud_b[2]; b4 = aud_b[4]; b6 = aud_b[6];
            pulse(1, 0, 0);
            chk("norm_fetch_muted", 32'(mute_a), 1);
            clk1(); clk1();
            chk("norm_first_audible", 32'(mute_a), 0);
            chk("norm_first_div", 32'(div_a), 81632);
            begin
                int k = 0;
                while (done_a !== 1'b1 && k < 300) begin clk1(); k++; end
                chk("norm_done_timeout", (k < 300) ? 1 : 0, 1);
            end
            chk("norm_done_busy", 32'(busy_a), 0);
            chk("norm_done_addr", 32'(addr_a), 0);
            idle_cycles(40);
            chk("norm_note1_ticks", aud_a[1] - base1, 3);
            chk("norm_note5_ticks", aud_a[5] - base5, 2);
            chk("norm_done_count", done_cnt_a - based, 1);
            chk("noend_done_count", done_cnt_b - n, 1);
            chk("noend_note0", aud_b[0] - b0, 1);
            chk("noend_note2", aud_b[2] - b2, 1);
            chk("noend_note4", aud_b[4] - b4, 1);
            chk("noend_note6", aud_b[6] - b6, 1);
            chk("noend_idle", 32'(busy_b), 0);
        end
        $display("scenario normal/no-end-marker: checks=%0d failures=%0d", checks, failures);

        // ---- loop ----
        loop_en = 1;
        base1 = aud_a[1]; base5 = aud_a[5]; based = done_cnt_a;
        pulse(1, 0, 0);
        begin
            int k = 0;
            while ((aud_a[1] - base1) < 4 && k < 400) begin clk1(); k++; end
            chk("loop_timeout", (k < 400) ? 1 : 0, 1);
        end
        chk("loop_note5_ticks", aud_a[5] - base5, 2);
        chk("loop_no_done", done_cnt_a - based, 0);
        chk("loop_audible_again", 32'(div_a), 81632);
        pulse(0, 0, 1);
        chk("loop_stop_busy", 32'(busy_a), 0);
        chk("loop_stop_mute", 32'(mute_a), 1);
        chk("loop_stop_done", 32'(done_a), 0);
        idle_cycles(3);
        chk("loop_stop_no_done", done_cnt_a - based, 0);
        loop_en = 0;
        $display("scenario loop: checks=%0d failures=%0d", checks, failures);

        // ---- pause ----
        base1 = aud_a[1];
        pulse(1, 0, 0);
        begin
            int k = 0;
            while ((aud_a[1] - base1) < 1 && k < 100) begin clk1(); k++; end
            chk("pause_first_tick_timeout", (k < 100) ? 1 : 0, 1);
        end
        pulse(0, 1, 0);
        chk("pause_mute", 32'(mute_a), 1);
        idle_cycles(40);
        chk("pause_still_muted", 32'(mute_a), 1);
        chk("pause_still_busy", 32'(busy_a), 1);
        pulse(1, 0, 0);
        chk("resume_unmuted", 32'(mute_a), 0);
        begin
            int k = 0;
            while (mute_a !== 1'b1 && k < 100) begin clk1(); k++; end
            chk("resume_end_timeout", (k < 100) ? 1 : 0, 1);
        end
        chk("pause_note1_ticks", aud_a[1] - base1, 3);
        pulse(0, 0, 1);
        idle_cycles(3);
        $display("scenario pause: checks=%0d failures=%0d", checks, failures);

        // ---- stop + pause + beat_tick together during PLAY ----
        based = done_cnt_a;
        pulse(1, 0, 0);
        begin
            int k = 0;
            while (mute_a !== 1'b0 && k < 20) begin clk1(); k++; end
            chk("simul_play_timeout", (k < 20) ? 1 : 0, 1);
        end
        auto_tick = 0;
        beat_tick = 1;
        pulse(0, 1, 1);
        beat_tick = 0;
        auto_tick = 1;
        chk("simul_busy", 32'(busy_a), 0);
        chk("simul_mute", 32'(mute_a), 1);
        chk("simul_done", 32'(done_a), 0);
        chk("simul_note_held", 32'(div_a), 81632);
        idle_cycles(3);
        chk("simul_no_done", done_cnt_a - based, 0);
        $display("scenario simultaneous: checks=%0d failures=%0d", checks, failures);

        // ---- randomized ----
        for (int i = 0; i < 64; i++)
            rom_a[i] = {4'($urandom_range(0, 15)),
                        ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 6))};
        for (int i = 0; i < 4; i++)
            rom_b[i] = {4'($urandom_range(0, 15)),
                        ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 3))};
        auto_tick = 0;
        for (int c = 0; c < 5000; c++) begin
            beat_tick = ($urandom_range(0, 2) == 0);
            play      = ($urandom_range(0, 19) == 0);
            pause     = ($urandom_range(0, 29) == 0);
            stop      = ($urandom_range(0, 119) == 0);
            rst_n     = ($urandom_range(0, 799) != 0);
            if ($urandom_range(0, 59) == 0) loop_en = 1'($urandom_range(0, 1));
            clk1();
        end
        play = 0; pause = 0; stop = 0; beat_tick = 0; rst_n = 1;
        clk1();
        $display("scenario random: checks=%0d failures=%0d", checks, failures);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
